// File: rtl/wb_arbiter_if.sv
// Bus bundle for the write-back arbiter: ALU/load inputs, register-file
// write port, decode read addresses and the stall/occupancy outputs.
interface wb_arbiter_if #(
    parameter int AW = 2
);
    logic        AluValid;
    logic [4:0]  AluReg;
    logic [31:0] AluData;
    logic        LdIssue;
    logic [4:0]  LdIssueReg;
    logic        LdValid;
    logic [4:0]  LdReg;
    logic [31:0] LdData;
    logic        LdReady;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic        Stall;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [AW:0] BufCount;

    modport slave (
        input  AluValid, AluReg, AluData, LdIssue, LdIssueReg,
               LdValid, LdReg, LdData, ReadReg1, ReadReg2,
        output LdReady, Stall, RegWrite, WriteReg, WriteData, BufCount
    );

    modport master (
        output AluValid, AluReg, AluData, LdIssue, LdIssueReg,
               LdValid, LdReg, LdData, ReadReg1, ReadReg2,
        input  LdReady, Stall, RegWrite, WriteReg, WriteData, BufCount
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: owns the register-file write port, gives ALU results
// priority and queues load returns in a DEPTH-entry FIFO. A 32-bit busy
// scoreboard of outstanding loads drives the decode Stall.
// Optional: define WB_LOAD_BYPASS_EN to let a load returning into an empty
// FIFO with no ALU traffic go straight to the write port (one cycle sooner).
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    wb_arbiter_if.slave   bus
);
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ld_ent_t;

    ld_ent_t      mem [DEPTH];
    ld_ent_t      head;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]  count;
    logic [31:0]  busy;
    logic [31:0]  clr_mask, set_mask;
    logic         empty, push, pop, byp;

    assign empty        = (count == '0);
    assign bus.LdReady  = (count < (AW+1)'(DEPTH));
    assign bus.BufCount = count;
    assign head         = mem[rd_ptr];

`ifdef WB_LOAD_BYPASS_EN
    assign byp = bus.LdValid & bus.LdReady & empty & ~bus.AluValid;
`else
    assign byp = 1'b0;
`endif

    // A bypassed load never enters the FIFO; LdValid while full is dropped.
    assign push = bus.LdValid & bus.LdReady & ~byp;
    assign pop  = ~bus.AluValid & ~empty;

    // Reg 0 is never tracked, so it can never stall decode.
    assign bus.Stall = ((bus.ReadReg1 != 5'd0) & busy[bus.ReadReg1])
                     | ((bus.ReadReg2 != 5'd0) & busy[bus.ReadReg2]);

    // FIFO storage needs no reset; validity is carried by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{rd: bus.LdReg, data: bus.LdData};
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Scoreboard masks: a load leaving for the write port clears its bit,
    // a new issue sets one; set is applied last so it wins on a collision.
    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (pop)      clr_mask[head.rd]   = 1'b1;
        else if (byp) clr_mask[bus.LdReg] = 1'b1;
        if (bus.LdIssue && bus.LdIssueReg != 5'd0) set_mask[bus.LdIssueReg] = 1'b1;
    end

    // Busy register for pending loads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) busy <= '0;
        else        busy <= (busy & ~clr_mask) | set_mask;
    end

    // Registered write port: ALU first, then FIFO head (or bypassed load).
    // Address/data hold when idle; writes to reg 0 are suppressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.RegWrite  <= 1'b0;
            bus.WriteReg  <= '0;
            bus.WriteData <= '0;
        end else if (bus.AluValid) begin
            bus.RegWrite  <= (bus.AluReg != 5'd0);
            bus.WriteReg  <= bus.AluReg;
            bus.WriteData <= bus.AluData;
        end else if (pop) begin
            bus.RegWrite  <= (head.rd != 5'd0);
            bus.WriteReg  <= head.rd;
            bus.WriteData <= head.data;
        end else if (byp) begin
            bus.RegWrite  <= (bus.LdReg != 5'd0);
            bus.WriteReg  <= bus.LdReg;
            bus.WriteData <= bus.LdData;
        end else begin
            bus.RegWrite  <= 1'b0;
        end
    end
endmodule
